// File: rtl/icache_sa.sv
// N-way set-associative instruction cache between fetch and the instruction-memory bus.
// Flop-based line storage gives a single-cycle tag/data compare. Replacement is
// lowest-invalid-way first, then a per-set round-robin pointer.
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   cpu_req/cpu_addr         fetch request and address, accepted when cpu_gnt=1
//   mpu_exec_allow           execute permission for cpu_addr, sampled with cpu_req
//   cpu_gnt                  ready to accept (idle only)
//   cpu_rvalid/cpu_rdata     one-cycle data response (rdata is 0 otherwise)
//   cpu_fault                one-cycle fault response (NX or bus error)
//   inv_all                  invalidate every line and round-robin pointer
//   mem_req/mem_addr/mem_gnt word read request handshake
//   mem_rvalid/mem_rdata/mem_fault  read return, fault qualified by rvalid
module icache_sa #(
  parameter int unsigned LINE_BYTES = 16,
  parameter int unsigned SETS       = 32,
  parameter int unsigned WAYS       = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req,
  input  logic [31:0] cpu_addr,
  input  logic        mpu_exec_allow,
  output logic        cpu_gnt,
  output logic [31:0] cpu_rdata,
  output logic        cpu_rvalid,
  output logic        cpu_fault,
  input  logic        inv_all,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  input  logic        mem_fault
);

  localparam int unsigned OffW  = $clog2(LINE_BYTES);
  localparam int unsigned IdxW  = $clog2(SETS);
  localparam int unsigned TagW  = 32 - OffW - IdxW;
  localparam int unsigned Words = LINE_BYTES / 4;
  localparam int unsigned WselW = $clog2(Words);
  localparam int unsigned WayW  = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [2:0] {
    StIdle, StLookup, StFault, StRefillReq, StRefillWait, StInstall, StResp
  } state_e;

  state_e state_q, state_d;
  logic [31:0]      addr_q, addr_d;
  logic [WselW-1:0] fill_cnt_q, fill_cnt_d;
  logic             kill_q, kill_d;
  logic             fault_q, fault_d;
  logic [WayW-1:0]  victim_q, victim_d;
  logic             victim_rr_q, victim_rr_d;

  logic [SETS-1:0]  valid_q [WAYS];
  logic [TagW-1:0]  tag_q   [WAYS][SETS];
  logic [31:0]      data_q  [WAYS][SETS][Words];
  logic [WayW-1:0]  rr_q    [SETS];
  logic [31:0]      buf_q   [Words];

  logic [IdxW-1:0]  idx;
  logic [TagW-1:0]  tag;
  logic [WselW-1:0] wsel;
  logic [WAYS-1:0]  hit_vec;
  logic [31:0]      hit_word;
  logic [WayW-1:0]  victim;
  logic             victim_rr;
  logic             buf_we;
  logic             install_en;

  assign idx  = addr_q[OffW +: IdxW];
  assign tag  = addr_q[31 -: TagW];
  assign wsel = addr_q[2 +: WselW];

  // Parallel compare of all ways in the addressed set.
  always_comb begin
    hit_vec  = '0;
    hit_word = '0;
    for (int w = 0; w < WAYS; w++) begin
      hit_vec[w] = valid_q[w][idx] && (tag_q[w][idx] == tag);
      if (hit_vec[w]) hit_word = hit_word | data_q[w][idx][wsel];
    end
  end

  // Descending scan so the lowest-numbered invalid way wins.
  always_comb begin
    victim    = rr_q[idx];
    victim_rr = 1'b1;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[w][idx]) begin
        victim    = WayW'(w);
        victim_rr = 1'b0;
      end
    end
  end

  // A same-cycle inv_all beats the install.
  assign install_en = (state_q == StInstall) && !kill_q && !inv_all;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    fill_cnt_d  = fill_cnt_q;
    kill_d      = kill_q;
    fault_d     = fault_q;
    victim_d    = victim_q;
    victim_rr_d = victim_rr_q;
    buf_we      = 1'b0;
    cpu_gnt     = 1'b0;
    cpu_rvalid  = 1'b0;
    cpu_fault   = 1'b0;
    cpu_rdata   = '0;
    mem_req     = 1'b0;
    mem_addr    = '0;
    unique case (state_q)
      StIdle: begin
        cpu_gnt = 1'b1;
        if (cpu_req) begin
          addr_d  = cpu_addr;
          state_d = mpu_exec_allow ? StLookup : StFault;
        end
      end
      StFault: begin
        cpu_fault = 1'b1;
        state_d   = StIdle;
      end
      StLookup: begin
        if (|hit_vec) begin
          cpu_rvalid = 1'b1;
          cpu_rdata  = hit_word;
          state_d    = StIdle;
        end else begin
          victim_d    = victim;
          victim_rr_d = victim_rr;
          fill_cnt_d  = '0;
          kill_d      = 1'b0;
          fault_d     = 1'b0;
          state_d     = StRefillReq;
        end
      end
      StRefillReq: begin
        mem_req  = 1'b1;
        mem_addr = {addr_q[31:OffW], fill_cnt_q, 2'b00};
        if (mem_gnt) state_d = StRefillWait;
      end
      StRefillWait: begin
        if (mem_rvalid) begin
          if (mem_fault) begin
            fault_d = 1'b1;
            state_d = StResp;
          end else begin
            buf_we = 1'b1;
            if (fill_cnt_q == WselW'(Words - 1)) begin
              state_d = StInstall;
            end else begin
              fill_cnt_d = fill_cnt_q + WselW'(1);
              state_d    = StRefillReq;
            end
          end
        end
      end
      StInstall: state_d = StResp;
      StResp: begin
        if (fault_q) begin
          cpu_fault = 1'b1;
        end else begin
          cpu_rvalid = 1'b1;
          cpu_rdata  = buf_q[wsel];
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // Invalidation while a refill is in flight suppresses its install.
    if (inv_all && (state_q inside {StRefillReq, StRefillWait, StInstall})) kill_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      fill_cnt_q  <= '0;
      kill_q      <= 1'b0;
      fault_q     <= 1'b0;
      victim_q    <= '0;
      victim_rr_q <= 1'b0;
      for (int w = 0; w < WAYS; w++) valid_q[w] <= '0;
      for (int s = 0; s < SETS; s++) rr_q[s] <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      fill_cnt_q  <= fill_cnt_d;
      kill_q      <= kill_d;
      fault_q     <= fault_d;
      victim_q    <= victim_d;
      victim_rr_q <= victim_rr_d;
      if (inv_all) begin
        for (int w = 0; w < WAYS; w++) valid_q[w] <= '0;
        for (int s = 0; s < SETS; s++) rr_q[s] <= '0;
      end else if (install_en) begin
        valid_q[victim_q][idx] <= 1'b1;
        // Pointer only advances when it actually picked the victim.
        if (victim_rr_q) rr_q[idx] <= (WAYS == 1) ? '0 : rr_q[idx] + WayW'(1);
      end
    end
  end

  // Tag and data contents need no reset; valid bits gate them.
  always_ff @(posedge clk) begin
    if (buf_we) buf_q[fill_cnt_q] <= mem_rdata;
    if (install_en) begin
      tag_q[victim_q][idx] <= tag;
      for (int i = 0; i < Words; i++) data_q[victim_q][idx][i] <= buf_q[i];
    end
  end

  a_single_hit: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == StLookup) |-> $onehot0(hit_vec));

endmodule

// File: doc/icache_sa.md
# icache_sa

Parametrised N-way set-associative instruction cache between the fetch stage and the external instruction-memory bus. It is the generalised successor of the direct-mapped fetch cache and adds configurable associativity with round-robin replacement, a real request/grant handshake on both sides, MPU execute gating, fault-safe refill and invalidate-during-refill protection. Line storage is flops, so tag and data compare is single-cycle.

## Interface
- LINE_BYTES, 16, line size in bytes; power of two, at least 8.
- SETS, 32, number of sets; power of two, at least 2.
- WAYS, 2, associativity; 1, 2 or 4.
- clk  in  1  clock; everything is rising-edge.
- rst_n  in  1  reset, asynchronous, active-low.
- cpu_req  in  1  fetch request; accepted when cpu_gnt=1.
- cpu_addr  in  32  physical fetch address; bits [1:0] ignored.
- mpu_exec_allow  in  1  MPU execute permission for cpu_addr; sampled with cpu_req.
- cpu_gnt  out  1  ready to accept; 1 only in IDLE.
- cpu_rdata  out  32  fetched word; valid only with cpu_rvalid, otherwise 0.
- cpu_rvalid  out  1  one-cycle response pulse carrying data.
- cpu_fault  out  1  one-cycle response pulse for a fault (NX or bus); cpu_rdata=0.
- inv_all  in  1  invalidate all lines; single-cycle pulse, honoured in any state.
- mem_req  out  1  word read request; held until mem_gnt.
- mem_addr  out  32  word-aligned read address.
- mem_gnt  in  1  request accepted this cycle.
- mem_rvalid  in  1  read data or fault returned.
- mem_rdata  in  32  read data.
- mem_fault  in  1  bus error, qualified by mem_rvalid.

## Operation
- Address split: offset = log2(LINE_BYTES), index = log2(SETS), tag = the remaining upper bits; word_sel = addr[offset-1:2].
- State: per way and set, one valid bit, the tag, and LINE_BYTES/4 data words. Per set, one round-robin pointer of log2(WAYS) bits.
- IDLE: cpu_gnt=1. When cpu_req=1, register addr_q and the allow bit. If allowed, go to LOOKUP; otherwise go to FAULT.
- FAULT: cpu_fault=1 for one cycle, then IDLE. No lookup and no memory access occur.
- LOOKUP: compare all ways of set index(addr_q) in parallel.
  - Hit: cpu_rvalid=1 and cpu_rdata = the hit word; return to IDLE.
  - Miss: choose a victim, clear fill_cnt, clear kill, go to REFILL_REQ.
  - Multiple ways matching is illegal. Verification asserts it never happens.
- Victim selection: the lowest-numbered invalid way if any exists. Otherwise the way at the set's rr pointer, and the pointer increments modulo WAYS when the line is installed.
- REFILL_REQ: mem_req=1 and mem_addr = line base + fill_cnt*4. On mem_gnt, go to REFILL_WAIT. Words are filled in order from the line base.
- REFILL_WAIT: wait for mem_rvalid.
  - mem_fault=1: abort. Go to RESP with the fault flag set. The victim way is untouched; its old valid, tag and data are kept.
  - Otherwise: write mem_rdata into the line buffer word fill_cnt. If fill_cnt is the last word, go to INSTALL; else increment fill_cnt and go to REFILL_REQ.
- INSTALL: copy the buffer into the victim way, set valid and tag, and update rr, unless kill=1. Go to RESP.
- RESP: cpu_rvalid=1 with buffer[word_sel(addr_q)], or cpu_fault=1 if the fault flag is set. Then IDLE.
- inv_all:
  - Clears every valid bit and every rr pointer at the next edge.
  - Asserted in REFILL_REQ, REFILL_WAIT or INSTALL, it also sets kill. The refill still completes and the word is still returned, but nothing is installed.
  - inv_all in the same cycle as INSTALL: invalidation wins and the line stays invalid.
- mem_rvalid arriving outside REFILL_WAIT is ignored.

## Timing
- Reset values: state IDLE, cpu_gnt=1, cpu_rvalid=0, cpu_fault=0, cpu_rdata=0, mem_req=0, mem_addr=0. All valid bits, rr pointers, fill_cnt and kill are 0. Data contents are don't-care.
- Hit: request accepted at edge T, cpu_rvalid high in cycle T+1, cpu_gnt high again in cycle T+2.
- NX: cpu_fault high in cycle T+1.
- Miss with zero-wait memory (gnt in the same cycle as req, rvalid the cycle after gnt), per word: 1 REFILL_REQ cycle + 1 REFILL_WAIT cycle.
- Miss total: 1 LOOKUP + 2·W + 1 INSTALL + 1 RESP cycles, where W = LINE_BYTES/4. For the default parameters, cpu_rvalid is high 11 cycles after acceptance.
- Each response is exactly one cycle, with exactly one response per accepted request.
- Reset asserted mid-refill drops mem_req asynchronously. A later mem_rvalid is ignored.

## Test plan
- Cold miss at 0x0000_1004 with memory returning 0xA0..0xA3 → mem_addr sequence 0x1000, 0x1004, 0x1008, 0x100C. cpu_rvalid fires with 0xA1 at cycle 11. A re-fetch of 0x1008 hits with 0xA2 one cycle after acceptance, with no mem_req.
- Default parameters, WAYS=2: fill 0x0000, 0x0200, 0x0400 (same set) → the third fill evicts way 0. 0x0200 still hits; 0x0000 misses.
- mpu_exec_allow=0 on a request for 0x2000 → cpu_fault pulse at T+1 with cpu_rdata=0. mem_req stays 0 throughout.
- mem_fault on the third refill word → cpu_fault pulse, line not installed. Re-fetching the same address misses again.
- inv_all pulsed during REFILL_WAIT → data still returned via cpu_rvalid. Re-fetching the same address misses. All previously valid lines also miss.
- rst_n low while mem_req=1 → mem_req=0 immediately and cpu_gnt=1. A late mem_rvalid causes no response.
